// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory port arbiter.
// Widths match the fetch stage's memory interface.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared port.
// slave is the arbiter's view, master the environment's.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              flush;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_select.sv
// Priority select with a data-streak limit so a
// waiting fetch cannot be starved by the data stage.
module mem_arb_select #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_eff,
  input  logic dm_req,
  input  logic grant_en,
  output logic sel_if,
  output logic sel_dm
);

  localparam logic [STREAK_W-1:0] SAT =
    STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic                sat;
  logic                pick_dm;

  assign sat     = (streak_q == SAT);
  assign pick_dm = dm_req & ~(if_eff & sat);
  assign sel_dm  = grant_en & pick_dm;
  assign sel_if  = grant_en & ~pick_dm & if_eff;

  // Count data grants taken while fetch is waiting
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak_q <= '0;
    end else if (sel_dm & if_eff) begin
      streak_q <= sat ? streak_q : streak_q + 1'b1;
    end else if (sel_if | sel_dm) begin
      streak_q <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data stage,
// one transaction at a time, dropping flushed fetches.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = MEM_ADDR_W,
  parameter int DATA_W          = MEM_DATA_W,
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic              we_q;
  logic              drop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              if_rvalid_q, dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_eff, grant_en;
  logic              sel_if, sel_dm;
  logic              done, if_done, dm_done;

  assign if_eff   = bus.if_req & ~bus.flush;
  assign grant_en = rst & (state_q == IDLE);
  assign done     = (state_q == RESP) & bus.mem_rvalid;
  assign if_done  = done & (owner_q == OWN_IF)
                  & ~drop_q & ~bus.flush;
  assign dm_done  = done & (owner_q == OWN_DM);

  mem_arb_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK),
    .STREAK_W        (STREAK_W)
  ) u_sel (
    .clk      (clk),
    .rst      (rst),
    .if_eff   (if_eff),
    .dm_req   (bus.dm_req),
    .grant_en (grant_en),
    .sel_if   (sel_if),
    .sel_dm   (sel_dm)
  );

  assign bus.if_gnt    = sel_if;
  assign bus.dm_gnt    = sel_dm;
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: grant, wait for accept, wait for response
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_if | sel_dm)  state_d = REQ;
      REQ:     if (bus.mem_ready)    state_d = RESP;
      RESP:    if (bus.mem_rvalid)   state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Latch the granted request and track flushed fetches
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (sel_if | sel_dm) begin
        owner_q <= sel_dm ? OWN_DM : OWN_IF;
        we_q    <= sel_dm & bus.dm_we;
        addr_q  <= sel_dm ? bus.dm_addr : bus.if_addr;
        wdata_q <= sel_dm ? bus.dm_wdata : '0;
      end
      if (done) begin
        drop_q <= 1'b0;
      end else if (bus.flush && owner_q == OWN_IF &&
                   state_q != IDLE) begin
        drop_q <= 1'b1;
      end
    end
  end

  // One-cycle response pulse to the owner
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= if_done;
      if_rdata_q  <= if_done ? bus.mem_rdata : '0;
      dm_rvalid_q <= dm_done;
      dm_rdata_q  <= (dm_done & ~we_q) ? bus.mem_rdata : '0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between two requesters: the fetch stage (read-only) and the data-memory stage (load/store).
- Runs one transaction at a time, arbitrates between requesters, forwards responses to the owner, and drops stale fetch responses on a branch flush.
- Sits between the fetch and memory stages and the external memory model.

Parameters:
- ADDR_W, 9, memory address width (matches the fetch stage's mem_address).
- DATA_W, 64, memory data width.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting.
- STREAK_W, 3, streak counter width; must satisfy 2^STREAK_W > MAX_DATA_STREAK.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetch read data.
- flush  in  1  branch taken; invalidates any fetch in flight.
- dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  load data valid or store acknowledged, one-cycle pulse.
- dm_rdata  out  DATA_W  load data; 0 for stores.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response valid (read data or write ack).
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - state = IDLE, streak = 0, drop = 0.
  - All outputs, including mem_req and the registered response outputs, are 0.
  - Applies mid-transaction: the in-flight transaction is abandoned.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Effective fetch request: if_eff = if_req & ~flush.
  - Selection: if dm_req & ~(if_eff & streak == MAX_DATA_STREAK), pick data; else if if_eff, pick fetch.
  - if_gnt / dm_gnt are combinational and asserted only in IDLE for the selected requester.
  - On a grant, register owner, we (0 for fetch), addr and wdata, then go to REQ.
  - mem_rvalid is ignored in IDLE (covers a stale response after reset).
- Streak counter:
  - On a data grant while if_eff = 1: streak += 1, saturating at MAX_DATA_STREAK.
  - On a fetch grant, or a data grant with if_eff = 0: streak = 0.
- REQ:
  - mem_req = 1 and mem_* are driven from the registers.
  - Hold until mem_ready = 1, then go to RESP; mem_req drops in the next cycle.
- RESP:
  - Wait for mem_rvalid.
  - On mem_rvalid, the next cycle has the owner's rvalid = 1 and rdata = mem_rdata (stores give rdata = 0), and state = IDLE.
  - Best-case latency: grant at cycle N, mem_req at N+1, response pulse at N+3 when mem_ready is high at N+1 and mem_rvalid is high at N+2.
  - Next grant is possible in the cycle the response pulse is visible.
- Flush:
  - flush = 1 while owner = fetch and state is REQ or RESP sets drop = 1.
  - The memory transaction still completes normally.
  - At completion, if_rvalid stays 0 and drop clears.
  - Flush while the data stage owns the port has no effect.
  - Flush in IDLE suppresses a fetch grant that cycle.
- Only one transaction is ever outstanding. A requester never sees rvalid without a preceding gnt.
- Simultaneous requests: data wins unless the streak is saturated; on a saturated streak, fetch wins once and the streak resets.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, REQ, RESP}.
  - owner_t enum {OWN_IF, OWN_DM}.
  - Default ADDR_W / DATA_W constants shared with the fetch stage.
- Sub-module mem_arb_select holds the streak counter and priority select: inputs if_eff, dm_req, grant_en; outputs sel_if, sel_dm.
- FSM, request registers and response path live in the top module.

Test Plan:
- Lone fetch: if_req = 1, if_addr = 0x010, mem_ready and mem_rvalid each one cycle after the previous step, mem_rdata = 0xDEADBEEF_00000001 -> if_gnt at cycle 0, mem_req at cycle 1 with addr 0x010 and we = 0, if_rvalid with that data at cycle 3.
- Store: dm_req = 1, dm_we = 1, addr 0x020, wdata 0x55 -> mem_we = 1 and mem_wdata = 0x55 while mem_req is high; dm_rvalid pulses with dm_rdata = 0.
- Contention and starvation: if_req and dm_req held high, MAX_DATA_STREAK = 4 -> grant order DM, DM, DM, DM, IF, DM, ...
- Flush during fetch: fetch granted, flush pulsed in RESP, mem_rdata = 0x1234 returned -> if_rvalid never asserted; the next fetch completes normally.
- Stalling memory: mem_ready held low for 5 cycles -> mem_req and mem_addr stable for all 5 cycles, no new grant, single response pulse.
- Reset mid-transaction: rst = 0 in RESP, then mem_rvalid arrives after release -> all outputs 0, no rvalid pulse, state IDLE.
